// File: rtl/nmos_seq_pkg.sv
// Shared types and constants for the NMOS flag-bank bus sequencer.
package nmos_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FIN    = 2'd3
  } seq_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/nmos_rr_arb2.sv
// Two-way arbiter: fixed A priority or round-robin with a pointer that moves on grant.
module nmos_rr_arb2
  import nmos_seq_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic win_c,
  output logic valid_c
);

  logic ptr;

  // Tie goes to the preferred port; a lone requester always wins
  always_comb begin
    valid_c = req_a | req_b;
    if (req_a && req_b) begin
      win_c = FIXED_PRI ? PORT_A : ptr;
    end else if (req_b) begin
      win_c = PORT_B;
    end else begin
      win_c = PORT_A;
    end
  end

  // Pointer favours the port that was not served last
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PORT_A;
    end else if (update && valid_c) begin
      ptr <= ~win_c;
    end
  end

endmodule

// File: rtl/nmos_flag_seq.sv
// Bus sequencer for a bank of two-phase flag cells: arbitrates two requesters and
// aligns LD/OE/SE/DB strobes to a full PHI2 phase.
module nmos_flag_seq
  import nmos_seq_pkg::*;
#(
  parameter int unsigned NFLAGS    = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned TIMEOUT   = 64,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic              main_clk,
  input  logic              R,
  input  logic              C1,
  input  logic              C2,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic              a_val,
  input  logic              b_val,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic              a_err,
  output logic              b_err,
  output logic              a_rdata,
  output logic              b_rdata,
  output logic [NFLAGS-1:0] ld,
  output logic [NFLAGS-1:0] oe,
  output logic              se,
  output logic              db_o,
  output logic              db_oe,
  input  logic              db_i
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  // FIN adds one cycle, so leaving ARM/ACTIVE here puts done TIMEOUT cycles after grant
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 2);

  seq_state_t         state, state_nxt;
  logic               owner, owner_nxt;
  logic               is_rd, is_rd_nxt;
  logic               err_q, err_nxt;
  logic               cap, cap_nxt;
  logic [TCNT_W-1:0]  tcnt, tcnt_nxt;
  logic               a_gnt_nxt, b_gnt_nxt, a_done_nxt, b_done_nxt;
  logic               a_err_nxt, b_err_nxt, a_rdata_nxt, b_rdata_nxt;
  logic [NFLAGS-1:0]  ld_nxt, oe_nxt;
  logic               se_nxt, db_o_nxt, db_oe_nxt;

  logic               win_c, any_req_c, grant_c, bad_sel_c, timeout_c;
  logic               gwe_c, gval_c;
  logic [SEL_W-1:0]   gsel_c;
  logic [NFLAGS-1:0]  cell_c;

  nmos_rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk     (main_clk),
    .rst     (R),
    .req_a   (a_req),
    .req_b   (b_req),
    .update  (grant_c),
    .win_c   (win_c),
    .valid_c (any_req_c)
  );

  // Grant decode: only in IDLE during PHI1 so strobes settle before PHI2
  always_comb begin
    grant_c   = (state == ST_IDLE) && C1 && any_req_c;
    gsel_c    = (win_c == PORT_B) ? b_sel : a_sel;
    gwe_c     = (win_c == PORT_B) ? b_we  : a_we;
    gval_c    = (win_c == PORT_B) ? b_val : a_val;
    bad_sel_c = (32'(gsel_c) >= NFLAGS);
    cell_c    = NFLAGS'(1) << gsel_c;
    timeout_c = ((state == ST_ARM) || (state == ST_ACTIVE)) && (tcnt == TCNT_LAST);
  end

  // State and all registered outputs
  always_ff @(posedge main_clk) begin
    if (R) begin
      state   <= ST_IDLE;
      owner   <= PORT_A;
      is_rd   <= 1'b0;
      err_q   <= 1'b0;
      cap     <= 1'b0;
      tcnt    <= '0;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rdata <= 1'b0;
      b_rdata <= 1'b0;
      ld      <= '0;
      oe      <= '0;
      se      <= 1'b0;
      db_o    <= 1'b0;
      db_oe   <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      is_rd   <= is_rd_nxt;
      err_q   <= err_nxt;
      cap     <= cap_nxt;
      tcnt    <= tcnt_nxt;
      a_gnt   <= a_gnt_nxt;
      b_gnt   <= b_gnt_nxt;
      a_done  <= a_done_nxt;
      b_done  <= b_done_nxt;
      a_err   <= a_err_nxt;
      b_err   <= b_err_nxt;
      a_rdata <= a_rdata_nxt;
      b_rdata <= b_rdata_nxt;
      ld      <= ld_nxt;
      oe      <= oe_nxt;
      se      <= se_nxt;
      db_o    <= db_o_nxt;
      db_oe   <= db_oe_nxt;
    end
  end

  // Next state: bad index skips straight to FIN, timeout overrides phase tracking
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_c) state_nxt = bad_sel_c ? ST_FIN : ST_ARM;
      ST_ARM:    if (timeout_c) state_nxt = ST_FIN;
                 else if (C2) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (timeout_c || !C2) state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of strobes, capture, timeout counter and per-port responses
  always_comb begin
    owner_nxt   = owner;
    is_rd_nxt   = is_rd;
    err_nxt     = err_q;
    cap_nxt     = cap;
    tcnt_nxt    = tcnt;
    a_gnt_nxt   = a_gnt;
    b_gnt_nxt   = b_gnt;
    a_done_nxt  = 1'b0;
    b_done_nxt  = 1'b0;
    a_err_nxt   = 1'b0;
    b_err_nxt   = 1'b0;
    a_rdata_nxt = a_rdata;
    b_rdata_nxt = b_rdata;
    ld_nxt      = ld;
    oe_nxt      = oe;
    se_nxt      = se;
    db_o_nxt    = db_o;
    db_oe_nxt   = db_oe;
    case (state)
      ST_IDLE: begin
        if (grant_c) begin
          owner_nxt = win_c;
          a_gnt_nxt = (win_c == PORT_A);
          b_gnt_nxt = (win_c == PORT_B);
          is_rd_nxt = ~gwe_c;
          err_nxt   = bad_sel_c;
          cap_nxt   = 1'b0;
          tcnt_nxt  = '0;
          if (!bad_sel_c) begin
            ld_nxt    = gwe_c ? cell_c : '0;
            oe_nxt    = gwe_c ? '0 : cell_c;
            se_nxt    = gwe_c & gval_c;
            db_o_nxt  = gwe_c;
            db_oe_nxt = gwe_c;
          end
        end
      end
      ST_ARM, ST_ACTIVE: begin
        tcnt_nxt = tcnt + TCNT_W'(1);
        if (C2 && is_rd) cap_nxt = db_i;
        if (timeout_c) begin
          err_nxt = 1'b1;
          cap_nxt = 1'b0;
        end
        if (state_nxt == ST_FIN) begin
          ld_nxt    = '0;
          oe_nxt    = '0;
          se_nxt    = 1'b0;
          db_o_nxt  = 1'b0;
          db_oe_nxt = 1'b0;
        end
      end
      ST_FIN: begin
        a_gnt_nxt = 1'b0;
        b_gnt_nxt = 1'b0;
        if (owner == PORT_A) begin
          a_done_nxt  = 1'b1;
          a_err_nxt   = err_q;
          a_rdata_nxt = is_rd & ~err_q & cap;
        end else begin
          b_done_nxt  = 1'b1;
          b_err_nxt   = err_q;
          b_rdata_nxt = is_rd & ~err_q & cap;
        end
      end
      default: begin
        a_gnt_nxt = 1'b0;
        b_gnt_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nmos_flag_seq.sv
// Directed bench for nmos_flag_seq: a round-robin and a fixed-priority instance share
// stimulus; a small flag-cell model drives db_i from the round-robin instance.
module tb_nmos_flag_seq;

  localparam int unsigned NF = 6;
  localparam int unsigned SW = 3;
  localparam int unsigned TO = 16;

  logic main_clk = 1'b0;
  logic R, C1, C2;
  logic a_req, b_req, a_we, b_we, a_val, b_val;
  logic [SW-1:0] a_sel, b_sel;
  logic db_i;
  logic c2_hold = 1'b0;

  logic rr_a_gnt, rr_b_gnt, rr_a_done, rr_b_done, rr_a_err, rr_b_err, rr_a_rdata, rr_b_rdata;
  logic [NF-1:0] rr_ld, rr_oe;
  logic rr_se, rr_db_o, rr_db_oe;
  logic fx_a_gnt, fx_b_gnt, fx_a_done, fx_b_done, fx_a_err, fx_b_err, fx_a_rdata, fx_b_rdata;
  logic [NF-1:0] fx_ld, fx_oe;
  logic fx_se, fx_db_o, fx_db_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ph = 0;

  logic [NF-1:0] flags;
  logic preset_go;
  int   preset_idx;
  logic preset_val;
  logic dual_gnt = 1'b0;

  typedef struct {
    logic          port;
    logic          we;
    logic [SW-1:0] sel;
    logic          val;
    logic          pre;
    logic          pre_v;
    logic [NF-1:0] e_ld;
    logic [NF-1:0] e_oe;
    logic          e_se;
    logic          e_dbo;
    logic          e_dboe;
    logic          e_err;
    logic          e_rd;
  } vec_t;

  vec_t vecs [8];

  nmos_flag_seq #(.NFLAGS(NF), .SEL_W(SW), .TIMEOUT(TO), .FIXED_PRI(1'b0)) u_rr (
    .main_clk(main_clk), .R(R), .C1(C1), .C2(C2),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_sel(a_sel), .b_sel(b_sel), .a_val(a_val), .b_val(b_val),
    .a_gnt(rr_a_gnt), .b_gnt(rr_b_gnt), .a_done(rr_a_done), .b_done(rr_b_done),
    .a_err(rr_a_err), .b_err(rr_b_err), .a_rdata(rr_a_rdata), .b_rdata(rr_b_rdata),
    .ld(rr_ld), .oe(rr_oe), .se(rr_se), .db_o(rr_db_o), .db_oe(rr_db_oe), .db_i(db_i)
  );

  nmos_flag_seq #(.NFLAGS(NF), .SEL_W(SW), .TIMEOUT(TO), .FIXED_PRI(1'b1)) u_fx (
    .main_clk(main_clk), .R(R), .C1(C1), .C2(C2),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_sel(a_sel), .b_sel(b_sel), .a_val(a_val), .b_val(b_val),
    .a_gnt(fx_a_gnt), .b_gnt(fx_b_gnt), .a_done(fx_a_done), .b_done(fx_b_done),
    .a_err(fx_a_err), .b_err(fx_b_err), .a_rdata(fx_a_rdata), .b_rdata(fx_b_rdata),
    .ld(fx_ld), .oe(fx_oe), .se(fx_se), .db_o(fx_db_o), .db_oe(fx_db_oe), .db_i(db_i)
  );

  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  // Two-phase clock: C1 high 4, dead 2, C2 high 4, dead 2
  initial begin
    C1 = 1'b0;
    C2 = 1'b0;
    forever begin
      @(posedge main_clk);
      #2;
      ph = (ph == 11) ? 0 : ph + 1;
      C1 = (ph < 4);
      C2 = !c2_hold && (ph >= 6) && (ph < 10);
    end
  end

  // Flag cells latch SE while LD is high during PHI2; OE puts the flag on DB
  always @(posedge main_clk) begin
    if (R) flags <= '0;
    else if (preset_go) flags[preset_idx] <= preset_val;
    else if (C2) begin
      for (int i = 0; i < NF; i++) if (rr_ld[i]) flags[i] <= rr_se;
    end
  end
  assign db_i = |(rr_oe & flags);

  always @(negedge main_clk) begin
    if ((rr_a_gnt && rr_b_gnt) || (fx_a_gnt && fx_b_gnt)) dual_gnt <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preset(input int idx, input logic v);
    @(negedge main_clk);
    preset_idx = idx;
    preset_val = v;
    preset_go  = 1'b1;
    @(negedge main_clk);
    preset_go  = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int gcyc, dcyc;
    logic got_g, got_d, strobe_bad, saw_c2, other_done, err_act, rd_act, gnt_act;
    logic [2*NF+2:0] busy_act;
    v = vecs[idx];
    if (v.pre) preset(int'(v.sel), v.pre_v);
    @(negedge main_clk);
    if (v.port) begin
      b_req = 1'b1; b_we = v.we; b_sel = v.sel; b_val = v.val;
    end else begin
      a_req = 1'b1; a_we = v.we; a_sel = v.sel; a_val = v.val;
    end
    got_g = 1'b0; gcyc = 0; dcyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge main_clk);
      if (v.port ? rr_b_gnt : rr_a_gnt) begin
        got_g = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    check($sformatf("vec%0d grant", idx), 32'(got_g), 32'd1);
    got_d = 1'b0; strobe_bad = 1'b0; saw_c2 = 1'b0; other_done = 1'b0;
    err_act = 1'b0; rd_act = 1'b0; gnt_act = 1'b1; busy_act = '1;
    for (int k = 0; k < 60 && got_g; k++) begin
      if (v.port ? rr_b_done : rr_a_done) begin
        got_d = 1'b1;
        dcyc = cyc;
        err_act = v.port ? rr_b_err : rr_a_err;
        rd_act = v.port ? rr_b_rdata : rr_a_rdata;
        gnt_act = v.port ? rr_b_gnt : rr_a_gnt;
        busy_act = {rr_ld, rr_oe, rr_se, rr_db_o, rr_db_oe};
        break;
      end
      if (v.e_err) begin
        if (rr_ld != '0 || rr_oe != '0) strobe_bad = 1'b1;
      end else if (C2) begin
        saw_c2 = 1'b1;
        if ({rr_ld, rr_oe, rr_se, rr_db_o, rr_db_oe} !==
            {v.e_ld, v.e_oe, v.e_se, v.e_dbo, v.e_dboe}) strobe_bad = 1'b1;
      end
      if (v.port ? rr_a_done : rr_b_done) other_done = 1'b1;
      @(negedge main_clk);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check($sformatf("vec%0d done", idx), 32'(got_d), 32'd1);
    check($sformatf("vec%0d strobes", idx), 32'(!strobe_bad && (v.e_err || saw_c2)), 32'd1);
    check($sformatf("vec%0d err", idx), 32'(err_act), 32'(v.e_err));
    check($sformatf("vec%0d idle at done", idx), 32'({gnt_act, busy_act}), 32'd0);
    check($sformatf("vec%0d other port quiet", idx), 32'(other_done), 32'd0);
    if (!v.we && !v.e_err) check($sformatf("vec%0d rdata", idx), 32'(rd_act), 32'(v.e_rd));
    if (v.we && !v.e_err) check($sformatf("vec%0d flag cell", idx), 32'(flags[v.sel]), 32'(v.val));
    if (v.e_err) check($sformatf("vec%0d err latency<=2", idx), 32'((dcyc - gcyc) <= 2), 32'd1);
  endtask

  task automatic tie_rounds();
    logic ordr [3];
    logic ordf [3];
    int nr, nf;
    logic pa_r, pb_r, pa_f, pb_f, idle;
    for (int i = 0; i < 3; i++) begin ordr[i] = 1'bx; ordf[i] = 1'bx; end
    nr = 0; nf = 0;
    @(negedge main_clk);
    a_we = 1'b1; a_sel = 3'd1; a_val = 1'b1;
    b_we = 1'b1; b_sel = 3'd2; b_val = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    pa_r = rr_a_gnt; pb_r = rr_b_gnt; pa_f = fx_a_gnt; pb_f = fx_b_gnt;
    for (int k = 0; k < 200 && (nr < 3 || nf < 3); k++) begin
      @(negedge main_clk);
      if (nr < 3 && rr_a_gnt && !pa_r) begin ordr[nr] = 1'b0; nr++; end
      if (nr < 3 && rr_b_gnt && !pb_r) begin ordr[nr] = 1'b1; nr++; end
      if (nf < 3 && fx_a_gnt && !pa_f) begin ordf[nf] = 1'b0; nf++; end
      if (nf < 3 && fx_b_gnt && !pb_f) begin ordf[nf] = 1'b1; nf++; end
      pa_r = rr_a_gnt; pb_r = rr_b_gnt; pa_f = fx_a_gnt; pb_f = fx_b_gnt;
      if (nr >= 3 && nf >= 3) begin a_req = 1'b0; b_req = 1'b0; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr grant 1 (A)", 32'(ordr[0]), 32'd0);
    check("rr grant 2 (B)", 32'(ordr[1]), 32'd1);
    check("rr grant 3 (A)", 32'(ordr[2]), 32'd0);
    check("fixed grant 1 (A)", 32'(ordf[0]), 32'd0);
    check("fixed grant 2 (A)", 32'(ordf[1]), 32'd0);
    check("fixed grant 3 (A)", 32'(ordf[2]), 32'd0);
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge main_clk);
      if (!rr_a_gnt && !rr_b_gnt && !fx_a_gnt && !fx_b_gnt) begin idle = 1'b1; break; end
    end
    check("tie rounds drain", 32'(idle), 32'd1);
  endtask

  task automatic timeout_test();
    int gcyc, dcyc;
    logic got_g, got_d, err_act, rd_act;
    logic [2*NF+2:0] busy_act;
    preset(4, 1'b1);
    c2_hold = 1'b1;
    repeat (3) @(negedge main_clk);
    a_we = 1'b0; a_sel = 3'd4; a_val = 1'b0; a_req = 1'b1;
    got_g = 1'b0; got_d = 1'b0; gcyc = 0; dcyc = 0;
    err_act = 1'b0; rd_act = 1'b1; busy_act = '1;
    for (int k = 0; k < 40; k++) begin
      @(negedge main_clk);
      if (rr_a_gnt) begin got_g = 1'b1; gcyc = cyc; break; end
    end
    for (int k = 0; k < 40 && got_g; k++) begin
      @(negedge main_clk);
      if (rr_a_done) begin
        got_d = 1'b1; dcyc = cyc;
        err_act = rr_a_err; rd_act = rr_a_rdata;
        busy_act = {rr_ld, rr_oe, rr_se, rr_db_o, rr_db_oe};
        break;
      end
    end
    a_req = 1'b0;
    c2_hold = 1'b0;
    check("timeout done seen", 32'(got_d), 32'd1);
    check("timeout latency", 32'(dcyc - gcyc), 32'(TO));
    check("timeout err", 32'(err_act), 32'd1);
    check("timeout rdata", 32'(rd_act), 32'd0);
    check("timeout strobes cleared", 32'(busy_act), 32'd0);
  endtask

  task automatic reset_test();
    logic got_c2, any_done, got_g, got_d;
    logic [1:0] first_g;
    logic [2*NF+4:0] after_rst;
    @(negedge main_clk);
    a_we = 1'b1; a_sel = 3'd1; a_val = 1'b1; a_req = 1'b1;
    got_c2 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge main_clk);
      if (rr_a_gnt && C2) begin got_c2 = 1'b1; break; end
    end
    check("reset test reached PHI2", 32'(got_c2), 32'd1);
    R = 1'b1;
    a_req = 1'b0;
    @(negedge main_clk);
    after_rst = {rr_a_gnt, rr_b_gnt, rr_ld, rr_oe, rr_se, rr_db_o, rr_db_oe, rr_a_done, rr_b_done};
    check("mid-op reset clears strobes/gnt", 32'(after_rst), 32'd0);
    R = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge main_clk);
      if (rr_a_done || rr_b_done) any_done = 1'b1;
    end
    check("no done after reset", 32'(any_done), 32'd0);
    a_we = 1'b1; a_sel = 3'd3; a_val = 1'b1;
    b_we = 1'b1; b_sel = 3'd4; b_val = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    got_g = 1'b0; first_g = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge main_clk);
      if (rr_a_gnt || rr_b_gnt) begin got_g = 1'b1; first_g = {rr_a_gnt, rr_b_gnt}; break; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("tie after reset goes to A", 32'(first_g), 32'b10);
    got_d = 1'b0;
    for (int k = 0; k < 40 && got_g; k++) begin
      @(negedge main_clk);
      if (rr_a_done) begin got_d = 1'b1; break; end
    end
    check("post-reset A done", 32'(got_d), 32'd1);
  endtask

  initial begin
    R = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_sel = '0; b_sel = '0; a_val = 1'b0; b_val = 1'b0;
    preset_go = 1'b0; preset_idx = 0; preset_val = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 6'b100000, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 6'b000001, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge main_clk);
    check("reset outputs rr", 32'({rr_a_gnt, rr_b_gnt, rr_a_done, rr_b_done, rr_a_err, rr_b_err,
                                   rr_a_rdata, rr_b_rdata, rr_ld, rr_oe, rr_se, rr_db_o, rr_db_oe}), 32'd0);
    check("reset outputs fixed", 32'({fx_a_gnt, fx_b_gnt, fx_a_done, fx_b_done, fx_a_err, fx_b_err,
                                      fx_a_rdata, fx_b_rdata, fx_ld, fx_oe, fx_se, fx_db_o, fx_db_oe}), 32'd0);
    R = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);
    tie_rounds();
    timeout_test();
    reset_test();
    check("never two grants at once", 32'(dual_gnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
